// File: rtl/async_fifo_wr_arb.sv
// =============================================================================
// Module   : async_fifo_wr_arb
// Purpose  : Round-robin, burst-limited arbiter that shares the async FIFO
//            write port among NREQ valid/ready requesters (wclk domain).
// Option   : ASYNC_FIFO_WR_ARB_STATS_EN adds stall_cnt / beat_total counters.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module async_fifo_wr_arb #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DSIZE-1:0]         wdata,
  output logic                     winc,
  input  logic                     wfull,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              beat_total
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  gid, gid_nxt;
  logic [IDW-1:0]  last_grant, last_nxt;
  logic [IDW-1:0]  pick, idx;
  logic            found;
  logic [CW-1:0]   beat_cnt, beat_nxt;
  logic            in_burst;
  logic            cur_valid;

  // First valid requester searching upward from the one after last_grant.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign in_burst  = (state == BURST);
  assign cur_valid = req_valid[gid];
  assign winc      = in_burst && cur_valid && !wfull;
  assign wdata     = in_burst ? req_data[int'(gid)*DSIZE +: DSIZE] : '0;
  assign req_ready = (in_burst && !wfull) ? (NREQ'(1) << gid) : '0;
  assign grant     = in_burst ? (NREQ'(1) << gid) : '0;
  assign grant_id  = gid;

  always_comb begin
    state_nxt = state;
    gid_nxt   = gid;
    last_nxt  = last_grant;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BURST;
          gid_nxt   = pick;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        // A yield or the final permitted beat ends the burst; stalls never do.
        if (!cur_valid || (winc && beat_cnt == CW'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          last_nxt  = gid;
          gid_nxt   = '0;
          beat_nxt  = '0;
        end else if (winc) begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= IDLE;
      gid        <= '0;
      last_grant <= IDW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gid        <= gid_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  always_ff @(posedge wclk) begin
    if (wrst) begin
      stall_cnt  <= '0;
      beat_total <= '0;
    end else begin
      if (in_burst && cur_valid && wfull && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (winc)
        beat_total <= beat_total + 16'd1;
    end
  end
`endif

  always_ff @(posedge wclk) begin
    if (!wrst)
      assert (!(winc && wfull));
  end

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_arb.sv
// =============================================================================
// Module   : tb_async_fifo_wr_arb
// Purpose  : Self-checking bench for async_fifo_wr_arb with a spec-level model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_async_fifo_wr_arb;
  localparam int DSIZE = 8;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 4;

  logic                   wclk = 1'b0;
  logic                   wrst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DSIZE-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic [DSIZE-1:0]       wdata;
  logic                   winc;
  logic                   wfull;
  logic [NREQ-1:0]        grant;
  logic [1:0]             grant_id;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0]            stall_cnt;
  logic [15:0]            beat_total;
`endif

  always #5 wclk = ~wclk;

  async_fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wdata(wdata), .winc(winc), .wfull(wfull),
    .grant(grant), .grant_id(grant_id)
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .beat_total(beat_total)
`endif
  );

  // FIFO stand-in: manual wfull, or a 16-entry occupancy counter.
  logic wfull_man, use_fifo, rd;
  int   fifo_cnt;
  assign wfull = use_fifo ? (fifo_cnt >= 16) : wfull_man;

  logic [7:0] mem [NREQ][64];
  int head [NREQ];
  int tail [NREQ];

  int passed = 0;
  int total = 0;

  logic [7:0] wlog [512];
  int wn = 0;
  int glog_id [128];
  int glog_cyc [128];
  int gn = 0;
  int cyc = 0;
  int stall_obs = 0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] acc_s = '0;
  logic winc_s = 1'b0;

  int m_own, m_last, m_beats, m_stall, m_btot;
  bit model_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (head[i] != tail[i]);
      req_data[i*DSIZE +: DSIZE] = req_valid[i] ? mem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d);
    mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    refresh();
    wrst = 1'b1;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  task automatic wait_head(input int r, input int n);
    int guard;
    guard = 0;
    while (head[r] < n && guard < 50) begin
      tick();
      guard++;
    end
    if (head[r] < n) begin
      total++;
      $display("FAIL wait_head%0d: actual=%0d required=%0d", r, head[r], n);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model one edge.
  always @(negedge wclk) begin
    logic            in_b, v, e_winc, fnd;
    logic [NREQ-1:0] e_grant, e_ready;
    logic [7:0]      e_wdata;
    int              idx;
    cyc++;
    in_b = (m_own >= 0);
    v = 1'b0;
    e_grant = '0;
    e_wdata = 8'h00;
    if (model_ok && in_b) begin
      v = req_valid[m_own];
      e_grant = NREQ'(1) << m_own;
      e_wdata = req_data[m_own*DSIZE +: DSIZE];
    end
    e_winc = v && !wfull;
    e_ready = (in_b && !wfull) ? e_grant : '0;
    if (model_ok) begin
      chk("grant", 32'(grant), 32'(e_grant));
      chk("grant_id", 32'(grant_id), in_b ? 32'(m_own) : 32'd0);
      chk("winc", 32'(winc), 32'(e_winc));
      chk("wdata", 32'(wdata), 32'(e_wdata));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("beat_total", 32'(beat_total), 32'(m_btot));
`endif
    end
    acc_s = req_valid & req_ready;
    winc_s = winc;
    if (winc) begin
      wlog[wn] = wdata;
      wn++;
    end
    if (grant != 0 && prev_grant == 0) begin
      glog_id[gn] = int'(grant_id);
      glog_cyc[gn] = cyc;
      gn++;
    end
    prev_grant = grant;
    if (grant != 0 && !winc && wfull) stall_obs++;

    if (wrst) begin
      m_own = -1;
      m_last = NREQ - 1;
      m_beats = 0;
      m_stall = 0;
      m_btot = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (v && wfull && m_stall < 65535) m_stall++;
      if (e_winc) m_btot = (m_btot + 1) % 65536;
      if (!in_b) begin
        fnd = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!fnd && req_valid[idx]) begin
            fnd = 1'b1;
            m_own = idx;
            m_beats = 0;
          end
        end
      end else if (!v) begin
        m_last = m_own;
        m_own = -1;
      end else if (e_winc) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_last = m_own;
          m_own = -1;
          m_beats = 0;
        end
      end
    end
  end

  // Requester and FIFO bookkeeping just after each edge.
  always @(posedge wclk) begin
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_s[i]) head[i]++;
    if (use_fifo)
      fifo_cnt = fifo_cnt + (winc_s ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
    acc_s = '0;
    winc_s = 1'b0;
    refresh();
  end

  initial begin
    int wm, gm, c0;
    wrst = 1'b1;
    wfull_man = 1'b0;
    use_fifo = 1'b0;
    rd = 1'b0;
    fifo_cnt = 0;
    req_valid = '0;
    req_data = '0;
    m_own = -1;
    m_last = NREQ - 1;
    m_beats = 0;
    m_stall = 0;
    m_btot = 0;
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single requester, six beats: 4-beat burst, bubble, 2-beat burst.
    wm = wn; gm = gn;
    for (int k = 0; k < 6; k++) push(0, 8'hA0 + 8'(k));
    refresh();
    c0 = cyc + 1;
    repeat (15) tick();
    chk("t1_grants", 32'(gn - gm), 32'd2);
    chk("t1_latency", 32'(glog_cyc[gm] - c0), 32'd1);
    chk("t1_gap", 32'(glog_cyc[gm+1] - glog_cyc[gm]), 32'd5);
    chk("t1_id1", 32'(glog_id[gm+1]), 32'd0);
    chk("t1_beats", 32'(wn - wm), 32'd6);
    for (int k = 0; k < 6; k++) chk("t1_data", 32'(wlog[wm+k]), 32'(8'hA0 + k));

    // All requesters busy: strict 0,1,2,3,0 rotation with 4-beat bursts.
    do_reset();
    wm = wn; gm = gn;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k));
    refresh();
    repeat (50) tick();
    chk("t2_beats", 32'(wn - wm), 32'd32);
    for (int j = 0; j < 5; j++) chk("t2_order", 32'(glog_id[gm+j]), 32'(j % NREQ));
    for (int j = 0; j < 4; j++) chk("t2_gap", 32'(glog_cyc[gm+j+1] - glog_cyc[gm+j]), 32'd5);
    chk("t2_d0", 32'(wlog[wm+3]), 32'h03);
    chk("t2_d1", 32'(wlog[wm+4]), 32'h10);

    // Requester 2 stalled by wfull for 5 cycles after its 2nd beat.
    do_reset();
    wm = wn; gm = gn; stall_obs = 0;
    for (int k = 0; k < 4; k++) push(2, 8'hC0 + 8'(k));
    refresh();
    wait_head(2, 2);
    wfull_man = 1'b1;
    repeat (5) tick();
    wfull_man = 1'b0;
    repeat (10) tick();
    chk("t3_stalls", 32'(stall_obs), 32'd5);
    chk("t3_grants", 32'(gn - gm), 32'd1);
    chk("t3_id", 32'(glog_id[gm]), 32'd2);
    chk("t3_beats", 32'(wn - wm), 32'd4);
    for (int k = 0; k < 4; k++) chk("t3_data", 32'(wlog[wm+k]), 32'(8'hC0 + k));
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Requester 1 yields after one beat; requester 3 is next.
    do_reset();
    wm = wn; gm = gn;
    push(1, 8'hB1);
    push(3, 8'hD3);
    push(3, 8'hD4);
    refresh();
    repeat (15) tick();
    chk("t4_id0", 32'(glog_id[gm]), 32'd1);
    chk("t4_id1", 32'(glog_id[gm+1]), 32'd3);
    chk("t4_gap", 32'(glog_cyc[gm+1] - glog_cyc[gm]), 32'd3);
    chk("t4_d0", 32'(wlog[wm]), 32'hB1);
    chk("t4_d2", 32'(wlog[wm+2]), 32'hD4);

    // Reset in the middle of requester 3's burst.
    do_reset();
    gm = gn;
    for (int k = 0; k < 4; k++) push(3, 8'hE0 + 8'(k));
    refresh();
    wait_head(3, 2);
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_winc", 32'(winc), 32'd0);
    push(0, 8'h10);
    push(1, 8'h20);
    push(2, 8'h30);
    refresh();
    repeat (30) tick();
    chk("t5_id0", 32'(glog_id[gm]), 32'd3);
    chk("t5_after_rst", 32'(glog_id[gm+1]), 32'd0);

    // Fill a 16-entry FIFO from requester 0 with no reads, then drain 4.
    do_reset();
    use_fifo = 1'b1;
    fifo_cnt = 0;
    wm = wn;
    for (int k = 0; k < 20; k++) push(0, 8'h40 + 8'(k));
    refresh();
    repeat (40) tick();
    chk("t6_fill", 32'(wn - wm), 32'd16);
    chk("t6_grant", 32'(grant), 32'd1);
    chk("t6_winc", 32'(winc), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd0);
    rd = 1'b1;
    repeat (4) tick();
    rd = 1'b0;
    repeat (20) tick();
    chk("t6_total", 32'(wn - wm), 32'd20);
    chk("t6_last", 32'(wlog[wm+19]), 32'h53);
    chk("t6_idle", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
